// File: rtl/nonce_result_fifo_if.sv
// Handshake bundle between the hash macro array / regBank and the nonce result FIFO.
// The master side drives finds and readout controls; the FIFO is the slave.
interface nonce_result_fifo_if #(
   parameter int NUM_OF_MACROS = 4,
   parameter int DEPTH         = 4
);
   logic [NUM_OF_MACROS-1:0]    found_valid;
   logic [32*NUM_OF_MACROS-1:0] found_nonce;
   logic                        clear;
   logic                        irq_enable;
   logic [2:0]                  rd_byte_sel;
   logic                        pop;
   logic [7:0]                  rd_data;
   logic [$clog2(DEPTH):0]      fifo_count;
   logic                        empty;
   logic                        irq_out;

   modport master (
      output found_valid, found_nonce, clear, irq_enable, rd_byte_sel, pop,
      input  rd_data, fifo_count, empty, irq_out
   );

   modport slave (
      input  found_valid, found_nonce, clear, irq_enable, rd_byte_sel, pop,
      output rd_data, fifo_count, empty, irq_out
   );
endinterface

// File: rtl/nonce_result_fifo.sv
// Queues winning nonces from the hash macros for byte-wise host readout.
// Each macro has a one-deep pending slot; the lowest pending index drains into the FIFO.
module nonce_result_fifo #(
   parameter int NUM_OF_MACROS = 4,
   parameter int DEPTH         = 4
) (
   input logic                SPI_CLK,
   input logic                RST_N,
   nonce_result_fifo_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [NUM_OF_MACROS-1:0] pending;
   logic [31:0]              hold [NUM_OF_MACROS];
   logic [39:0]              mem [DEPTH];
   logic [PTR_W-1:0]         wr_ptr;
   logic [PTR_W-1:0]         rd_ptr;
   logic [CNT_W-1:0]         count;
   logic [CNT_W-1:0]         count_next;
   logic [7:0]               ovf_count;
   logic [7:0]               ovf_next;
   logic                     irq_q;

   logic                     push_any;
   logic                     do_push;
   logic                     do_pop;
   logic                     is_full;
   logic                     is_empty;
   logic [7:0]               push_id;
   logic [31:0]              push_nonce;
   logic [NUM_OF_MACROS-1:0] push_clear;
   logic [NUM_OF_MACROS-1:0] capture;
   logic [NUM_OF_MACROS-1:0] drop;
   logic [8:0]               ovf_sum;
   logic [39:0]              head;
   logic [7:0]               rd_byte;

   // A full FIFO still accepts a push when the head is popped in the same cycle.
   always_comb begin
      is_empty   = (count == '0);
      is_full    = (count == CNT_W'(DEPTH));
      do_pop     = bus.pop && !is_empty;
      push_any   = 1'b0;
      push_id    = '0;
      push_nonce = '0;
      for (int i = 0; i < NUM_OF_MACROS; i++) begin
         if (pending[i] && !push_any) begin
            push_any   = 1'b1;
            push_id    = 8'(i);
            push_nonce = hold[i];
         end
      end
      do_push = push_any && (!is_full || do_pop);

      push_clear = '0;
      capture    = '0;
      drop       = '0;
      for (int i = 0; i < NUM_OF_MACROS; i++) begin
         push_clear[i] = do_push && (push_id == 8'(i));
         capture[i]    = bus.found_valid[i] && (!pending[i] || push_clear[i]);
         drop[i]       = bus.found_valid[i] && pending[i] && !push_clear[i];
      end

      ovf_sum = {1'b0, ovf_count};
      for (int i = 0; i < NUM_OF_MACROS; i++) begin
         ovf_sum = ovf_sum + 9'(drop[i]);
      end
      ovf_next = ovf_sum[8] ? 8'hFF : ovf_sum[7:0];

      count_next = count;
      if (do_push && !do_pop) begin
         count_next = count + CNT_W'(1);
      end else if (!do_push && do_pop) begin
         count_next = count - CNT_W'(1);
      end
   end

   // clear acts like a synchronous reset and wins over every other action that cycle.
   always_ff @(posedge SPI_CLK or negedge RST_N) begin
      if (!RST_N) begin
         pending   <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         ovf_count <= '0;
         irq_q     <= 1'b0;
         for (int i = 0; i < NUM_OF_MACROS; i++) hold[i] <= '0;
         for (int j = 0; j < DEPTH; j++) mem[j] <= '0;
      end else if (bus.clear) begin
         pending   <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         ovf_count <= '0;
         irq_q     <= 1'b0;
         for (int i = 0; i < NUM_OF_MACROS; i++) hold[i] <= '0;
         for (int j = 0; j < DEPTH; j++) mem[j] <= '0;
      end else begin
         for (int i = 0; i < NUM_OF_MACROS; i++) begin
            if (capture[i]) begin
               pending[i] <= 1'b1;
               hold[i]    <= bus.found_nonce[32*i +: 32];
            end else if (push_clear[i]) begin
               pending[i] <= 1'b0;
            end
         end
         if (do_push) begin
            mem[wr_ptr] <= {push_id, push_nonce};
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count     <= count_next;
         ovf_count <= ovf_next;
         irq_q     <= bus.irq_enable && (count_next != '0);
      end
   end

   // Entry bytes read as zero while empty so stale memory never leaks to the host.
   always_comb begin
      head    = mem[rd_ptr];
      rd_byte = 8'h00;
      case (bus.rd_byte_sel)
         3'd0:    rd_byte = is_empty ? 8'h00 : head[7:0];
         3'd1:    rd_byte = is_empty ? 8'h00 : head[15:8];
         3'd2:    rd_byte = is_empty ? 8'h00 : head[23:16];
         3'd3:    rd_byte = is_empty ? 8'h00 : head[31:24];
         3'd4:    rd_byte = is_empty ? 8'h00 : head[39:32];
         3'd5:    rd_byte = 8'(count);
         3'd6:    rd_byte = ovf_count;
         default: rd_byte = 8'h00;
      endcase
   end

   assign bus.rd_data    = rd_byte;
   assign bus.fifo_count = count;
   assign bus.empty      = is_empty;
   assign bus.irq_out    = irq_q;
endmodule

// File: tb/tb_nonce_result_fifo.sv
// Directed bench for nonce_result_fifo: a queue-based reference model checked every cycle,
// plus hand-computed literal checks at the interesting points of each scenario.
module tb_nonce_result_fifo;
   localparam int NM = 4;
   localparam int DP = 4;

   logic SPI_CLK = 1'b0;
   logic RST_N   = 1'b1;
   int   num_checks = 0;
   int   num_errors = 0;

   nonce_result_fifo_if #(.NUM_OF_MACROS(NM), .DEPTH(DP)) bus ();

   nonce_result_fifo #(.NUM_OF_MACROS(NM), .DEPTH(DP)) dut (
      .SPI_CLK (SPI_CLK),
      .RST_N   (RST_N),
      .bus     (bus.slave)
   );

   always #10 SPI_CLK = ~SPI_CLK;

   // Reference model: the FIFO is a queue of {id, nonce}, one held nonce per macro.
   logic [39:0] m_q [$];
   bit [NM-1:0] m_pend = '0;
   bit [31:0]   m_hold [NM];
   int          m_ovf = 0;
   bit          m_irq = 1'b0;
   int          m_sel;
   bit          m_popping;
   bit          m_was_full;

   task automatic model_reset();
      m_q.delete();
      m_pend = '0;
      m_ovf  = 0;
      m_irq  = 1'b0;
   endtask

   always @(posedge SPI_CLK or negedge RST_N) begin
      if (!RST_N || bus.clear) begin
         model_reset();
      end else begin
         m_was_full = (m_q.size() == DP);
         m_popping  = bus.pop && (m_q.size() > 0);
         if (m_popping) void'(m_q.pop_front());
         m_sel = -1;
         for (int i = 0; i < NM; i++) if (m_pend[i] && m_sel < 0) m_sel = i;
         if (m_sel >= 0 && (!m_was_full || m_popping)) begin
            m_q.push_back({8'(m_sel), m_hold[m_sel]});
            m_pend[m_sel] = 1'b0;
         end
         for (int i = 0; i < NM; i++) begin
            if (bus.found_valid[i]) begin
               if (m_pend[i]) begin
                  m_ovf = (m_ovf < 255) ? m_ovf + 1 : 255;
               end else begin
                  m_pend[i] = 1'b1;
                  m_hold[i] = bus.found_nonce[32*i +: 32];
               end
            end
         end
         m_irq = bus.irq_enable && (m_q.size() != 0);
      end
   end

   function automatic logic [7:0] model_rd(input logic [2:0] sel);
      logic [39:0] h;
      h = (m_q.size() > 0) ? m_q[0] : 40'h0;
      case (sel)
         3'd0:    return h[7:0];
         3'd1:    return h[15:8];
         3'd2:    return h[23:16];
         3'd3:    return h[31:24];
         3'd4:    return h[39:32];
         3'd5:    return 8'(m_q.size());
         3'd6:    return 8'(m_ovf);
         default: return 8'h00;
      endcase
   endfunction

   task automatic check_eq(input string nm, input logic [31:0] got, input logic [31:0] exp);
      num_checks++;
      if (got !== exp) begin
         num_errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   always @(negedge SPI_CLK) begin
      check_eq("model fifo_count", 32'(bus.fifo_count), 32'(m_q.size()));
      check_eq("model empty", 32'(bus.empty), 32'(m_q.size() == 0));
      check_eq("model irq_out", 32'(bus.irq_out), 32'(m_irq));
      check_eq("model rd_data", 32'(bus.rd_data), 32'(model_rd(bus.rd_byte_sel)));
   end

   // Inputs change 2ns after the rising edge, so both DUT and model sample them settled.
   task automatic tick();
      @(posedge SPI_CLK);
      #2;
   endtask

   task automatic applyStimulus(input logic [NM-1:0] valid, input logic [32*NM-1:0] nonces,
                                input logic pop_in, input logic clear_in);
      bus.found_valid = valid;
      bus.found_nonce = nonces;
      bus.pop         = pop_in;
      bus.clear       = clear_in;
      bus.rd_byte_sel = bus.rd_byte_sel + 3'd1;
      tick();
      bus.found_valid = '0;
      bus.found_nonce = '0;
      bus.pop         = 1'b0;
      bus.clear       = 1'b0;
   endtask

   task automatic checkOutput(input string nm, input logic [2:0] sel, input logic [7:0] exp);
      bus.rd_byte_sel = sel;
      #1;
      check_eq(nm, 32'(bus.rd_data), 32'(exp));
   endtask

   task automatic checkStatus(input string nm, input int exp_count, input bit exp_empty,
                              input bit exp_irq);
      check_eq({nm, " count"}, 32'(bus.fifo_count), 32'(exp_count));
      check_eq({nm, " empty"}, 32'(bus.empty), 32'(exp_empty));
      check_eq({nm, " irq"}, 32'(bus.irq_out), 32'(exp_irq));
   endtask

   initial begin
      bus.found_valid = '0;
      bus.found_nonce = '0;
      bus.clear       = 1'b0;
      bus.irq_enable  = 1'b0;
      bus.rd_byte_sel = 3'd0;
      bus.pop         = 1'b0;
      #1 RST_N = 1'b0;

      tick();
      checkStatus("reset", 0, 1'b1, 1'b0);
      for (int s = 0; s < 4; s++) checkOutput("reset rd_data", 3'(s), 8'h00);
      tick();
      for (int s = 4; s < 8; s++) checkOutput("reset rd_data", 3'(s), 8'h00);
      RST_N = 1'b1;
      tick();

      $display("[TB] single find on macro 2");
      bus.irq_enable = 1'b1;
      applyStimulus(4'b0100, {32'h0, 32'hDEADBEEF, 64'h0}, 1'b0, 1'b0);
      checkStatus("single latency", 0, 1'b1, 1'b0);
      applyStimulus(4'b0000, '0, 1'b0, 1'b0);
      checkOutput("single sel0", 3'd0, 8'hEF);
      checkOutput("single sel1", 3'd1, 8'hBE);
      checkOutput("single sel2", 3'd2, 8'hAD);
      checkOutput("single sel3", 3'd3, 8'hDE);
      checkOutput("single sel4", 3'd4, 8'h02);
      checkStatus("single visible", 1, 1'b0, 1'b1);
      applyStimulus(4'b0000, '0, 1'b1, 1'b0);
      checkStatus("single popped", 0, 1'b1, 1'b0);
      checkOutput("single empty sel0", 3'd0, 8'h00);

      $display("[TB] simultaneous finds on macros 0,1,3");
      applyStimulus(4'b1011, {32'hD3D3D303, 32'h0, 32'hB1B1B101, 32'hA0A0A000}, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) applyStimulus(4'b0000, '0, 1'b0, 1'b0);
      checkOutput("simul count", 3'd5, 8'h03);
      checkOutput("simul ovf", 3'd6, 8'h00);
      checkOutput("simul head id0", 3'd4, 8'h00);
      applyStimulus(4'b0000, '0, 1'b1, 1'b0);
      checkOutput("simul head id1", 3'd4, 8'h01);
      applyStimulus(4'b0000, '0, 1'b1, 1'b0);
      checkOutput("simul head id3", 3'd4, 8'h03);
      checkOutput("simul head byte0", 3'd0, 8'h03);
      applyStimulus(4'b0000, '0, 1'b1, 1'b0);
      checkStatus("simul drained", 0, 1'b1, 1'b0);

      $display("[TB] overflow with full FIFO");
      for (int k = 0; k < 4; k++) applyStimulus(4'b0001, {96'h0, 32'(32'h10 + k)}, 1'b0, 1'b0);
      applyStimulus(4'b0010, {64'h0, 32'h0000AA01, 32'h0}, 1'b0, 1'b0);
      applyStimulus(4'b0010, {64'h0, 32'h0000BAD1, 32'h0}, 1'b0, 1'b0);
      applyStimulus(4'b0010, {64'h0, 32'h0000BAD2, 32'h0}, 1'b0, 1'b0);
      checkOutput("ovf count", 3'd6, 8'h02);
      checkOutput("ovf fifo_count", 3'd5, 8'h04);
      checkOutput("ovf head", 3'd0, 8'h10);
      applyStimulus(4'b0000, '0, 1'b1, 1'b0);
      checkStatus("full push+pop", 4, 1'b0, 1'b1);
      checkOutput("full push+pop head", 3'd0, 8'h11);
      checkOutput("full push+pop ovf", 3'd6, 8'h02);

      $display("[TB] streaming through pointer wrap");
      for (int k = 0; k < 3 * DP; k++) begin
         applyStimulus(4'(1 << (k % 4)), {4{32'(32'h5000_0000 + k)}}, 1'b1, 1'b0);
      end
      for (int k = 0; k < 12; k++) applyStimulus(4'b0000, '0, 1'b1, 1'b0);
      checkStatus("wrap drained", 0, 1'b1, 1'b0);

      $display("[TB] clear with concurrent find and pop");
      applyStimulus(4'b0100, {32'h0, 32'h22222222, 64'h0}, 1'b0, 1'b0);
      applyStimulus(4'b0000, '0, 1'b0, 1'b0);
      applyStimulus(4'b1000, {32'h33333333, 96'h0}, 1'b0, 1'b0);
      applyStimulus(4'b0001, {96'h0, 32'h44444444}, 1'b1, 1'b1);
      checkStatus("clear", 0, 1'b1, 1'b0);
      checkOutput("clear ovf", 3'd6, 8'h00);
      checkOutput("clear count", 3'd5, 8'h00);
      for (int k = 0; k < 3; k++) applyStimulus(4'b0000, '0, 1'b0, 1'b0);
      checkStatus("clear nothing captured", 0, 1'b1, 1'b0);
      applyStimulus(4'b0000, '0, 1'b1, 1'b0);
      checkStatus("pop while empty", 0, 1'b1, 1'b0);

      $display("[TB] drop counter saturation");
      for (int k = 0; k < 4; k++) applyStimulus(4'b0001, {96'h0, 32'(32'h60 + k)}, 1'b0, 1'b0);
      applyStimulus(4'b0000, '0, 1'b0, 1'b0);
      applyStimulus(4'b1111, {4{32'h7777_0000}}, 1'b0, 1'b0);
      for (int k = 0; k < 63; k++) applyStimulus(4'b1111, {4{32'h8888_0000}}, 1'b0, 1'b0);
      checkOutput("sat 252", 3'd6, 8'hFC);
      applyStimulus(4'b1111, {4{32'h9999_0000}}, 1'b0, 1'b0);
      checkOutput("sat 255", 3'd6, 8'hFF);
      applyStimulus(4'b1111, {4{32'h9999_0000}}, 1'b0, 1'b0);
      checkOutput("sat hold", 3'd6, 8'hFF);
      checkStatus("sat full", 4, 1'b0, 1'b1);

      $display("[TB] asynchronous reset mid-operation");
      #3 RST_N = 1'b0;
      #1;
      checkStatus("async reset", 0, 1'b1, 1'b0);
      checkOutput("async reset ovf", 3'd6, 8'h00);
      applyStimulus(4'b0000, '0, 1'b0, 1'b0);
      RST_N = 1'b1;
      applyStimulus(4'b0010, {64'h0, 32'h01020304, 32'h0}, 1'b0, 1'b0);
      applyStimulus(4'b0000, '0, 1'b0, 1'b0);
      checkOutput("after reset sel0", 3'd0, 8'h04);
      checkOutput("after reset sel3", 3'd3, 8'h01);
      checkOutput("after reset sel4", 3'd4, 8'h01);
      checkStatus("after reset", 1, 1'b0, 1'b1);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end
endmodule
